tcdm_banked_mem_model: RTL and testbench

- Parametrised, multi-port, word-interleaved banked TCDM memory model for HWPE engine benches and FPGA smoke builds.
- Any port can reach any bank. Per-bank round-robin arbitration resolves conflicts.
- Supports configurable read latency, byte-enable writes and optional pseudo-random grant-stall injection.
- Exposes conflict and error observability so engine streamers are exercised under realistic contention.

---
 rtl/tcdm_banked_mem_model_if.sv | 26 ++
 rtl/tcdm_banked_mem_model.sv | 168 ++++++++++++++++
 tb/tb_tcdm_banked_mem_model.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcdm_banked_mem_model_if.sv
// TCDM bus bundle between engine master ports and the banked memory model.
// Requests flow master -> slave; grants and responses flow back.
interface tcdm_banked_mem_model_if #(
    parameter int NumPorts  = 4,
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
);
    logic [NumPorts-1:0]             req_i;
    logic [NumPorts*AddrWidth-1:0]   add_i;
    logic [NumPorts-1:0]             wen_i;
    logic [NumPorts*DataWidth/8-1:0] be_i;
    logic [NumPorts*DataWidth-1:0]   data_i;
    logic [NumPorts-1:0]             gnt_o;
    logic [NumPorts*DataWidth-1:0]   r_data_o;
    logic [NumPorts-1:0]             r_valid_o;

    modport master (
        output req_i, add_i, wen_i, be_i, data_i,
        input  gnt_o, r_data_o, r_valid_o
    );

    modport slave (
        input  req_i, add_i, wen_i, be_i, data_i,
        output gnt_o, r_data_o, r_valid_o
    );
endinterface

// File: rtl/tcdm_banked_mem_model.sv
// Word-interleaved multi-bank TCDM model with per-bank round-robin arbitration,
// fixed-latency responses, optional LFSR grant stalls and contention counters.
module tcdm_banked_mem_model #(
    parameter int          NumPorts     = 4,
    parameter int          NumBanks     = 4,
    parameter int          DataWidth    = 32,
    parameter int          AddrWidth    = 32,
    parameter int          WordsPerBank = 128,
    parameter int          ReadLatency  = 1,
    parameter int          StallThresh  = 4,
    parameter logic [15:0] LfsrSeed     = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          rstn,
    tcdm_banked_mem_model_if.slave        tcdm,
    input  logic                          stall_en_i,
    input  logic                          clr_i,
    output logic [31:0]                   conflict_cnt_o,
    output logic                          err_o
);
    localparam int BeW   = DataWidth / 8;
    localparam int Off   = $clog2(BeW);
    localparam int Bb    = $clog2(NumBanks);
    localparam int BankW = (Bb > 0) ? Bb : 1;
    localparam int PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int RowW  = (WordsPerBank > 1) ? $clog2(WordsPerBank) : 1;

    logic [DataWidth-1:0] mem [NumBanks][WordsPerBank];
    logic [PortW-1:0]     rr_ptr [NumBanks];
    logic [15:0]          lfsr;
    logic                 stall;

    logic [AddrWidth-1:0] word_addr [NumPorts];
    logic [AddrWidth-1:0] row_full  [NumPorts];
    logic [BankW-1:0]     bank_sel  [NumPorts];
    logic [NumPorts-1:0]  in_range;
    logic [DataWidth-1:0] resp_data [NumPorts];

    logic [NumPorts-1:0]  gnt;
    logic [NumBanks-1:0]  bank_busy;
    logic [PortW-1:0]     bank_win   [NumBanks];
    logic [NumBanks-1:0]  bank_we;
    logic [RowW-1:0]      bank_row   [NumBanks];
    logic [BeW-1:0]       bank_be    [NumBanks];
    logic [DataWidth-1:0] bank_wdata [NumBanks];

    logic [NumPorts-1:0]  valid_pipe [ReadLatency];
    logic [DataWidth-1:0] data_pipe  [ReadLatency][NumPorts];
    logic [32:0]          cnt_sum;

    assign stall = stall_en_i && (32'(lfsr[3:0]) < 32'(StallThresh));

    // Address decode; out-of-range reads respond with all-ones, writes respond with zero
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            word_addr[p] = tcdm.add_i[p*AddrWidth +: AddrWidth] >> Off;
            bank_sel[p]  = (Bb > 0) ? word_addr[p][BankW-1:0] : '0;
            row_full[p]  = word_addr[p] >> Bb;
            in_range[p]  = row_full[p] < AddrWidth'(WordsPerBank);
            resp_data[p] = '0;
            if (tcdm.wen_i[p]) begin
                resp_data[p] = in_range[p] ? mem[bank_sel[p]][row_full[p][RowW-1:0]] : '1;
            end
        end
    end

    always_comb begin
        int idx;
        int w;
        idx       = 0;
        w         = 0;
        gnt       = '0;
        bank_busy = '0;
        bank_we   = '0;
        for (int b = 0; b < NumBanks; b++) begin
            bank_win[b]   = '0;
            bank_row[b]   = '0;
            bank_be[b]    = '0;
            bank_wdata[b] = '0;
        end
        if (rstn && !stall) begin
            for (int b = 0; b < NumBanks; b++) begin
                for (int k = 0; k < NumPorts; k++) begin
                    idx = (int'(rr_ptr[b]) + k) % NumPorts;
                    if (!bank_busy[b] && tcdm.req_i[idx] && (int'(bank_sel[idx]) == b)) begin
                        bank_busy[b] = 1'b1;
                        bank_win[b]  = PortW'(idx);
                        gnt[idx]     = 1'b1;
                    end
                end
            end
        end
        // Out-of-range writes are granted and answered but never touch the array
        for (int b = 0; b < NumBanks; b++) begin
            w             = int'(bank_win[b]);
            bank_we[b]    = bank_busy[b] && !tcdm.wen_i[w] && in_range[w];
            bank_row[b]   = row_full[w][RowW-1:0];
            bank_be[b]    = tcdm.be_i[w*BeW +: BeW];
            bank_wdata[b] = tcdm.data_i[w*DataWidth +: DataWidth];
        end
    end

    assign tcdm.gnt_o = gnt;

    always_ff @(posedge clk) begin
        for (int b = 0; b < NumBanks; b++) begin
            for (int i = 0; i < BeW; i++) begin
                if (bank_we[b] && bank_be[b][i]) begin
                    mem[b][bank_row[b]][i*8 +: 8] <= bank_wdata[b][i*8 +: 8];
                end
            end
        end
    end

    // Response shift pipeline; reset flushes everything in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < ReadLatency; s++) begin
                valid_pipe[s] <= '0;
                for (int p = 0; p < NumPorts; p++) data_pipe[s][p] <= '0;
            end
        end else begin
            valid_pipe[0] <= gnt;
            for (int p = 0; p < NumPorts; p++) begin
                data_pipe[0][p] <= gnt[p] ? resp_data[p] : '0;
            end
            for (int s = 1; s < ReadLatency; s++) begin
                valid_pipe[s] <= valid_pipe[s-1];
                for (int p = 0; p < NumPorts; p++) data_pipe[s][p] <= data_pipe[s-1][p];
            end
        end
    end

    always_comb begin
        tcdm.r_valid_o = valid_pipe[ReadLatency-1];
        tcdm.r_data_o  = '0;
        for (int p = 0; p < NumPorts; p++) begin
            tcdm.r_data_o[p*DataWidth +: DataWidth] =
                valid_pipe[ReadLatency-1][p] ? data_pipe[ReadLatency-1][p] : '0;
        end
    end

    assign cnt_sum = {1'b0, conflict_cnt_o} + 33'($countones(tcdm.req_i & ~gnt));

    // Arbiter pointers, stall LFSR and observability state; clear beats increment
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < NumBanks; b++) rr_ptr[b] <= '0;
            lfsr           <= LfsrSeed;
            conflict_cnt_o <= '0;
            err_o          <= 1'b0;
        end else begin
            for (int b = 0; b < NumBanks; b++) begin
                if (bank_busy[b]) begin
                    rr_ptr[b] <= (int'(bank_win[b]) == NumPorts - 1) ? '0 : bank_win[b] + 1'b1;
                end
            end
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (clr_i) begin
                conflict_cnt_o <= '0;
                err_o          <= 1'b0;
            end else begin
                conflict_cnt_o <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
                if (|(gnt & ~in_range)) err_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tcdm_banked_mem_model.sv
// Bench for tcdm_banked_mem_model: directed scenarios plus random traffic checked
// against a flat word-array memory model with a response scoreboard.
module tb_tcdm_banked_mem_model;
    localparam int NP  = 4;
    localparam int NB  = 4;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int WPB = 128;
    localparam int RL  = 2;
    localparam int ST  = 16;
    localparam int BEW = DW / 8;
    localparam int TotalWords = NB * WPB;

    logic        clk      = 1'b0;
    logic        rstn     = 1'b0;
    logic        stall_en = 1'b0;
    logic        clr      = 1'b0;
    logic [31:0] conflict_cnt;
    logic        err;

    tcdm_banked_mem_model_if #(.NumPorts(NP), .DataWidth(DW), .AddrWidth(AW)) bus ();

    tcdm_banked_mem_model #(
        .NumPorts(NP), .NumBanks(NB), .DataWidth(DW), .AddrWidth(AW),
        .WordsPerBank(WPB), .ReadLatency(RL), .StallThresh(ST), .LfsrSeed(16'hACE1)
    ) dut (
        .clk(clk), .rstn(rstn), .tcdm(bus), .stall_en_i(stall_en), .clr_i(clr),
        .conflict_cnt_o(conflict_cnt), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct { int port; int due; logic [DW-1:0] data; } resp_t;

    logic [DW-1:0]    ref_mem [TotalWords];
    int               rr [NB];
    longint           ref_cnt;
    bit               ref_err;
    int               cyc;
    resp_t            resp_q [$];
    logic [NP-1:0]    exp_gnt, exp_rvalid;
    logic [NP*DW-1:0] exp_rdata;
    int               n_cmp, n_fail;

    function automatic int word_of(int p);
        logic [AW-1:0] a;
        a = bus.add_i[p*AW +: AW];
        return int'(a >> 2);
    endfunction

    task automatic set_port(input int p, input bit rq, input logic [AW-1:0] a, input bit wn,
                            input logic [BEW-1:0] b, input logic [DW-1:0] d);
        bus.req_i[p]            = rq;
        bus.add_i[p*AW +: AW]   = a;
        bus.wen_i[p]            = wn;
        bus.be_i[p*BEW +: BEW]  = b;
        bus.data_i[p*DW +: DW]  = d;
    endtask

    task automatic idle();
        for (int p = 0; p < NP; p++) set_port(p, 1'b0, '0, 1'b1, '0, '0);
        stall_en = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic model_reset();
        resp_q.delete();
        for (int b = 0; b < NB; b++) rr[b] = 0;
        ref_cnt = 0;
        ref_err = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Expected grant per bank: the requester closest at or after that bank's pointer.
    // With StallThresh at 16 every stall-enabled cycle is a stall.
    task automatic cycle();
        int best_dist [NB];
        int best_port [NB];
        int b, d;
        exp_gnt = '0;
        for (int k = 0; k < NB; k++) begin best_dist[k] = NP; best_port[k] = -1; end
        if (!stall_en) begin
            for (int p = 0; p < NP; p++) begin
                if (bus.req_i[p]) begin
                    b = word_of(p) % NB;
                    d = (p - rr[b] + NP) % NP;
                    if (d < best_dist[b]) begin best_dist[b] = d; best_port[b] = p; end
                end
            end
        end
        for (int k = 0; k < NB; k++) if (best_port[k] >= 0) exp_gnt[best_port[k]] = 1'b1;
        exp_rvalid = '0;
        exp_rdata  = '0;
        foreach (resp_q[i]) begin
            if (resp_q[i].due == cyc) begin
                exp_rvalid[resp_q[i].port]               = 1'b1;
                exp_rdata[resp_q[i].port*DW +: DW]      = resp_q[i].data;
            end
        end
        @(negedge clk);
    endtask

    task automatic advance();
        resp_t  r;
        resp_t  keep [$];
        longint misses;
        bit     oor;
        int     w;
        misses = 0;
        oor    = 1'b0;
        for (int p = 0; p < NP; p++) if (bus.req_i[p] && !exp_gnt[p]) misses++;
        for (int p = 0; p < NP; p++) begin
            if (exp_gnt[p]) begin
                w      = word_of(p);
                r.port = p;
                r.due  = cyc + RL;
                r.data = '0;
                if (bus.wen_i[p]) r.data = (w < TotalWords) ? ref_mem[w] : '1;
                if (w >= TotalWords) oor = 1'b1;
                resp_q.push_back(r);
                rr[w % NB] = (p + 1) % NP;
            end
        end
        for (int p = 0; p < NP; p++) begin
            w = word_of(p);
            if (exp_gnt[p] && !bus.wen_i[p] && w < TotalWords) begin
                for (int i = 0; i < BEW; i++)
                    if (bus.be_i[p*BEW + i]) ref_mem[w][i*8 +: 8] = bus.data_i[p*DW + i*8 +: 8];
            end
        end
        ref_cnt = clr ? 0 : (((ref_cnt + misses) > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : ref_cnt + misses);
        ref_err = clr ? 1'b0 : (ref_err | oor);
        foreach (resp_q[i]) if (resp_q[i].due > cyc) keep.push_back(resp_q[i]);
        resp_q = keep;
        @(posedge clk);
        #1 cyc++;
    endtask

    task automatic test_reset();
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, '0, 1'b1, '0, '0);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.gnt_o !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_gnt: got %h want 0", bus.gnt_o); end
        n_cmp++; if (bus.r_valid_o !== 4'b0 || bus.r_data_o !== '0) begin n_fail++; $display("[TB] FAIL reset_resp: got %h/%h want 0/0", bus.r_valid_o, bus.r_data_o); end
        n_cmp++; if (conflict_cnt !== 32'd0 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_obs: got cnt %0d err %b want 0 0", conflict_cnt, err); end
        @(posedge clk);
        #1 idle();
        rstn = 1'b1;
        model_reset();
        cyc = 0;
    endtask

    task automatic test_fill();
        for (int r = 0; r < WPB; r++) begin
            for (int p = 0; p < NP; p++) set_port(p, 1'b1, AW'((r*NB + p) * 4), 1'b0, 4'hF, DW'($urandom));
            cycle();
            n_cmp++; if (bus.gnt_o !== exp_gnt) begin n_fail++; $display("[TB] FAIL fill_gnt cyc %0d: got %h want %h", cyc, bus.gnt_o, exp_gnt); end
            n_cmp++; if (bus.r_valid_o !== exp_rvalid || bus.r_data_o !== exp_rdata) begin n_fail++; $display("[TB] FAIL fill_resp cyc %0d: got %h/%h want %h/%h", cyc, bus.r_valid_o, bus.r_data_o, exp_rvalid, exp_rdata); end
            n_cmp++; if (conflict_cnt !== ref_cnt[31:0]) begin n_fail++; $display("[TB] FAIL fill_cnt: got %0d want %0d", conflict_cnt, ref_cnt); end
            advance();
        end
        idle();
    endtask

    task automatic test_single_read();
        set_port(0, 1'b1, '0, 1'b0, 4'hF, 32'h1234_5678);
        cycle();
        n_cmp++; if (bus.gnt_o !== exp_gnt) begin n_fail++; $display("[TB] FAIL single_wr_gnt: got %h want %h", bus.gnt_o, exp_gnt); end
        advance();
        set_port(0, 1'b1, '0, 1'b1, '0, '0);
        cycle();
        n_cmp++; if (bus.gnt_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_rd_gnt: got %h want 1", bus.gnt_o); end
        advance();
        idle();
        for (int k = 1; k <= 3; k++) begin
            cycle();
            n_cmp++; if (bus.r_valid_o !== exp_rvalid || bus.r_data_o !== exp_rdata) begin n_fail++; $display("[TB] FAIL single_resp k=%0d: got %h/%h want %h/%h", k, bus.r_valid_o, bus.r_data_o, exp_rvalid, exp_rdata); end
            if (k == 2) begin
                n_cmp++; if (bus.r_valid_o[0] !== 1'b1 || bus.r_data_o[31:0] !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL single_rd_data: got %b/%h want 1/12345678", bus.r_valid_o[0], bus.r_data_o[31:0]); end
            end
            if (k == 3) begin
                n_cmp++; if (bus.r_valid_o[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL single_rd_once: got %b want 0", bus.r_valid_o[0]); end
            end
            advance();
        end
    endtask

    task automatic test_parallel_banks();
        longint cnt_before;
        cnt_before = ref_cnt;
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, AW'(4*p), 1'b1, '0, '0);
        cycle();
        n_cmp++; if (bus.gnt_o !== 4'hF) begin n_fail++; $display("[TB] FAIL par_gnt: got %h want f", bus.gnt_o); end
        advance();
        idle();
        for (int k = 1; k <= 3; k++) begin
            cycle();
            n_cmp++; if (bus.r_valid_o !== exp_rvalid || bus.r_data_o !== exp_rdata) begin n_fail++; $display("[TB] FAIL par_resp k=%0d: got %h/%h want %h/%h", k, bus.r_valid_o, bus.r_data_o, exp_rvalid, exp_rdata); end
            n_cmp++; if (conflict_cnt !== cnt_before[31:0]) begin n_fail++; $display("[TB] FAIL par_cnt: got %0d want %0d", conflict_cnt, cnt_before); end
            advance();
        end
    endtask

    task automatic test_conflict();
        do_reset();
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, '0, 1'b1, '0, '0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_cmp++; if (bus.gnt_o !== 4'(1 << (i % NP))) begin n_fail++; $display("[TB] FAIL conf_order i=%0d: got %h want %h", i, bus.gnt_o, 4'(1 << (i % NP))); end
            n_cmp++; if (conflict_cnt !== 32'(3*i)) begin n_fail++; $display("[TB] FAIL conf_cnt i=%0d: got %0d want %0d", i, conflict_cnt, 3*i); end
            n_cmp++; if (bus.r_valid_o !== exp_rvalid || bus.r_data_o !== exp_rdata) begin n_fail++; $display("[TB] FAIL conf_resp i=%0d: got %h/%h want %h/%h", i, bus.r_valid_o, bus.r_data_o, exp_rvalid, exp_rdata); end
            advance();
        end
        idle();
        cycle();
        n_cmp++; if (conflict_cnt !== 32'd15) begin n_fail++; $display("[TB] FAIL conf_total: got %0d want 15", conflict_cnt); end
        advance();
    endtask

    task automatic test_byte_enable();
        set_port(1, 1'b1, '0, 1'b0, 4'hF, '0);
        cycle();
        advance();
        set_port(1, 1'b1, '0, 1'b0, 4'b0101, 32'hAABB_CCDD);
        cycle();
        advance();
        set_port(1, 1'b1, '0, 1'b1, '0, '0);
        cycle();
        n_cmp++; if (bus.gnt_o !== 4'b0010) begin n_fail++; $display("[TB] FAIL be_rd_gnt: got %h want 2", bus.gnt_o); end
        advance();
        idle();
        for (int k = 1; k <= 2; k++) begin
            cycle();
            n_cmp++; if (bus.r_valid_o[1] !== 1'b1) begin n_fail++; $display("[TB] FAIL be_valid k=%0d: got %b want 1", k, bus.r_valid_o[1]); end
            n_cmp++; if (bus.r_data_o[63:32] !== ((k == 1) ? 32'h0 : 32'h00BB_00DD)) begin n_fail++; $display("[TB] FAIL be_data k=%0d: got %h want %h", k, bus.r_data_o[63:32], (k == 1) ? 32'h0 : 32'h00BB_00DD); end
            advance();
        end
    endtask

    task automatic test_stall();
        clr = 1'b1;
        cycle();
        advance();
        clr      = 1'b0;
        stall_en = 1'b1;
        set_port(0, 1'b1, AW'(16), 1'b1, '0, '0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_cmp++; if (bus.gnt_o !== 4'b0) begin n_fail++; $display("[TB] FAIL stall_gnt i=%0d: got %h want 0", i, bus.gnt_o); end
            advance();
        end
        stall_en = 1'b0;
        cycle();
        n_cmp++; if (bus.gnt_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL stall_release: got %h want 1", bus.gnt_o); end
        n_cmp++; if (conflict_cnt !== 32'd10) begin n_fail++; $display("[TB] FAIL stall_cnt: got %0d want 10", conflict_cnt); end
        advance();
        idle();
    endtask

    task automatic test_out_of_range();
        set_port(2, 1'b1, AW'(2048), 1'b1, '0, '0);
        cycle();
        n_cmp++; if (bus.gnt_o !== 4'b0100) begin n_fail++; $display("[TB] FAIL oor_gnt: got %h want 4", bus.gnt_o); end
        advance();
        idle();
        cycle();
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_err: got %b want 1", err); end
        advance();
        cycle();
        n_cmp++; if (bus.r_valid_o[2] !== 1'b1 || bus.r_data_o[95:64] !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL oor_data: got %b/%h want 1/ffffffff", bus.r_valid_o[2], bus.r_data_o[95:64]); end
        advance();
        set_port(1, 1'b1, AW'(2048 + 4), 1'b0, 4'hF, 32'hDEAD_BEEF);
        cycle();
        advance();
        set_port(1, 1'b1, AW'(4), 1'b1, '0, '0);
        cycle();
        advance();
        idle();
        for (int k = 1; k <= 2; k++) begin
            cycle();
            n_cmp++; if (bus.r_valid_o !== exp_rvalid || bus.r_data_o !== exp_rdata) begin n_fail++; $display("[TB] FAIL oor_wr_drop k=%0d: got %h/%h want %h/%h", k, bus.r_valid_o, bus.r_data_o, exp_rvalid, exp_rdata); end
            advance();
        end
        clr = 1'b1;
        cycle();
        advance();
        clr = 1'b0;
        cycle();
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL oor_clr: got %b want 0", err); end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NP; p++) begin
                set_port(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, TotalWords-1) * 4 + $urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), 4'($urandom), DW'($urandom));
            end
            clr = ($urandom_range(0, 31) == 0);
            cycle();
            n_cmp++; if (bus.gnt_o !== exp_gnt) begin n_fail++; $display("[TB] FAIL rnd_gnt cyc %0d: got %h want %h", cyc, bus.gnt_o, exp_gnt); end
            n_cmp++; if (bus.r_valid_o !== exp_rvalid || bus.r_data_o !== exp_rdata) begin n_fail++; $display("[TB] FAIL rnd_resp cyc %0d: got %h/%h want %h/%h", cyc, bus.r_valid_o, bus.r_data_o, exp_rvalid, exp_rdata); end
            n_cmp++; if (conflict_cnt !== ref_cnt[31:0] || err !== ref_err) begin n_fail++; $display("[TB] FAIL rnd_obs cyc %0d: got %0d/%b want %0d/%b", cyc, conflict_cnt, err, ref_cnt, ref_err); end
            advance();
        end
        idle();
    endtask

    task automatic test_reset_midflight();
        set_port(0, 1'b1, '0, 1'b1, '0, '0);
        cycle();
        advance();
        idle();
        rstn = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (bus.r_valid_o !== 4'b0) begin n_fail++; $display("[TB] FAIL midrst_async: got %h want 0", bus.r_valid_o); end
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_cmp++; if (bus.r_valid_o !== 4'b0 || bus.r_data_o !== '0) begin n_fail++; $display("[TB] FAIL midrst_resp k=%0d: got %h/%h want 0/0", k, bus.r_valid_o, bus.r_data_o); end
            advance();
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        idle();
        model_reset();
        test_reset();
        test_fill();
        test_single_read();
        test_parallel_banks();
        test_conflict();
        test_byte_enable();
        test_stall();
        test_out_of_range();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
